// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: AES InvSubBytes engine over valid/ready handshakes.
// Define INV_SUB_BYTES_PARALLEL_EN for a single-cycle 16-lookup build.
module inv_sub_bytes_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    output logic         ready_in,
    input  logic [127:0] state_in,
    output logic         valid_out,
    input  logic         ready_out,
    output logic [127:0] state_out
);

    // Inverse S-box, entry x at [2047-8x -: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_e;

    fsm_e         state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [127:0] out_q, out_d;

    function automatic logic [7:0] isb(input logic [7:0] x);
        return INV_SBOX[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [31:0] isb_word(input logic [31:0] w);
        return {isb(w[31:24]), isb(w[23:16]), isb(w[15:8]), isb(w[7:0])};
    endfunction

`ifdef INV_SUB_BYTES_PARALLEL_EN
    function automatic logic [127:0] isb_state(input logic [127:0] s);
        return {isb_word(s[127:96]), isb_word(s[95:64]),
                isb_word(s[63:32]), isb_word(s[31:0])};
    endfunction
`else
    logic [1:0] col_q, col_d;
    logic [6:0] col_base;

    assign col_base = 7'd127 - {col_q, 5'd0};
`endif

    // Next-state: accept, substitute column(s), hold result until taken.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        out_d   = out_q;
`ifndef INV_SUB_BYTES_PARALLEL_EN
        col_d   = col_q;
`endif
        unique case (1'b1)
            (state_q == IDLE): begin
                if (valid_in) begin
                    work_d  = state_in;
                    state_d = BUSY;
`ifndef INV_SUB_BYTES_PARALLEL_EN
                    col_d   = 2'd0;
`endif
                end
            end
            (state_q == BUSY): begin
`ifdef INV_SUB_BYTES_PARALLEL_EN
                work_d  = isb_state(work_q);
                out_d   = work_d;
                state_d = DONE;
`else
                work_d[col_base -: 32] = isb_word(work_q[col_base -: 32]);
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    out_d   = work_d;
                    state_d = DONE;
                end
`endif
            end
            (state_q == DONE): begin
                if (ready_out) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, working and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            out_q   <= '0;
`ifndef INV_SUB_BYTES_PARALLEL_EN
            col_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            out_q   <= out_d;
`ifndef INV_SUB_BYTES_PARALLEL_EN
            col_q   <= col_d;
`endif
        end
    end

    assign ready_in  = (state_q == IDLE);
    assign valid_out = (state_q == DONE);
    assign state_out = out_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq: directed and random checks of inv_sub_bytes_seq.
// Reference inverse S-box is derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_seq;

`ifdef INV_SUB_BYTES_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic         ready_in;
    logic [127:0] state_in;
    logic         valid_out;
    logic         ready_out;
    logic [127:0] state_out;

    int           ncmp = 0;
    int           nfail = 0;
    logic [7:0]   isb_ref [256];
    logic [127:0] last_exp;

    always #5 clk = ~clk;

    inv_sub_bytes_seq dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .state_in  (state_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .state_out (state_out)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = isb_ref[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present din, wait for accept, then wait for the result; returns at DONE.
    task automatic xact(input string tag, input logic [127:0] din,
                        input logic [127:0] exp, input int max_wait);
        int k;
        valid_in = 1'b1;
        state_in = din;
        k = 0;
        while (!ready_in && k < 50) begin
            tick();
            k++;
        end
        check1({tag, "/ready_in"}, ready_in, 1'b1);
        ncmp++;
        assert (k <= max_wait) else begin
            nfail++;
            $error("FAIL %s/accept_wait: observed %0d expected <=%0d", tag, k, max_wait);
        end
        tick();
        valid_in = 1'b0;
        state_in = rnd128();
        check1({tag, "/busy_ready_in"}, ready_in, 1'b0);
        k = 0;
        while (!valid_out && k < 50) begin
            check({tag, "/hold_prev"}, state_out, last_exp);
            tick();
            k++;
        end
        check_int({tag, "/latency"}, k, LAT);
        check({tag, "/result"}, state_out, exp);
        check1({tag, "/done_ready_in"}, ready_in, 1'b0);
        last_exp = exp;
    endtask

    initial begin
        logic [127:0] d, e;
        for (int x = 0; x < 256; x++)
            isb_ref[fwd_sbox(8'(x))] = 8'(x);
        last_exp = '0;

        // Reset with valid_in high must not accept anything.
        rst = 1'b1;
        valid_in = 1'b1;
        state_in = rnd128();
        ready_out = 1'b0;
        tick();
        tick();
        check1("rst/ready_in", ready_in, 1'b1);
        check1("rst/valid_out", valid_out, 1'b0);
        check("rst/state_out", state_out, 128'h0);
        valid_in = 1'b0;
        rst = 1'b0;
        tick();
        check1("rst/no_accept", ready_in, 1'b1);

        // Basic vector and single-cycle valid_out.
        ready_out = 1'b1;
        xact("basic", {4{32'h637c777b}}, {4{32'h00010203}}, 0);
        tick();
        check1("basic/valid_one_cycle", valid_out, 1'b0);
        check1("basic/release_ready_in", ready_in, 1'b1);

        // Corner bytes.
        xact("all16", {16{8'h16}}, {16{8'hff}}, 0);
        tick();
        xact("all00", {16{8'h00}}, {16{8'h52}}, 0);
        tick();
        xact("col0", {32'hb75a9d85, 96'h0}, {32'h20467567, {12{8'h52}}}, 0);
        tick();

        // Random vectors against the reference model.
        for (int n = 0; n < 8; n++) begin
            d = rnd128();
            xact("rand", d, ref_state(d), 0);
            tick();
        end

        // Backpressure: result held, new valid_in ignored.
        ready_out = 1'b0;
        d = rnd128();
        e = ref_state(d);
        xact("bp", d, e, 0);
        for (int n = 0; n < 5; n++) begin
            valid_in = 1'b1;
            state_in = rnd128();
            tick();
            check1("bp/valid_out", valid_out, 1'b1);
            check("bp/state_out", state_out, e);
            check1("bp/ready_in", ready_in, 1'b0);
        end
        valid_in = 1'b0;
        ready_out = 1'b1;
        tick();
        check1("bp/release_valid", valid_out, 1'b0);
        check1("bp/release_ready", ready_in, 1'b1);
        tick();
        check1("bp/no_queued_accept", ready_in, 1'b1);
        check("bp/hold_between", state_out, e);

        // Reset mid-operation discards the partial result.
        valid_in = 1'b1;
        state_in = rnd128();
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("midrst/ready_in", ready_in, 1'b1);
        check1("midrst/valid_out", valid_out, 1'b0);
        check("midrst/state_out", state_out, 128'h0);
        last_exp = '0;
        xact("midrst/after", {16{8'h63}}, {16{8'h00}}, 0);
        tick();

        // Back-to-back: second state waits one cycle for ready_in.
        d = rnd128();
        xact("b2b/first", d, ref_state(d), 0);
        d = rnd128();
        xact("b2b/second", d, ref_state(d), 1);
        tick();
        check1("b2b/final_idle", ready_in, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
